store_narrow_unit: RTL and testbench

STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

---
 rtl/store_narrow_unit.sv | 156 +++++++++++++++
 tb/tb_store_narrow_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_unit.sv
// Sub-word store engine: byte/half stores become a read-modify-write on a word-wide memory
// port, word stores go straight to a write. Misaligned or reserved-size requests are rejected.
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    // state    | meaning
    // ST_IDLE  | ready for a request; rejects bad ones with an err pulse
    // ST_READ  | mem_rd held until mem_ack, then merge the lane
    // ST_WRITE | mem_wr held with a stable word until mem_ack
    // ST_RESP  | single done cycle
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic [15:0]       data_q, data_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_legal;
    logic [31:0]       merged;

    always_comb begin
        req_legal = 1'b1;
        case (req_size)
            SZ_BYTE: req_legal = 1'b1;
            SZ_HALF: req_legal = ~req_addr[0];
            SZ_WORD: req_legal = (req_addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Only the lane being stored is replaced; the rest of the read word is preserved.
    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_BYTE) begin
            merged[8*lane_q +: 8] = data_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        lane_d      = lane_q;
        size_d      = size_q;
        data_d      = data_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_legal) begin
                        err_d = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        lane_d     = req_addr[1:0];
                        size_d     = req_size;
                        data_d     = req_data[15:0];
                        if (req_size == SZ_WORD) begin
                            mem_wdata_d = req_data;
                            mem_wr_d    = 1'b1;
                            state_d     = ST_WRITE;
                        end else begin
                            mem_rd_d = 1'b1;
                            state_d  = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    mem_wdata_d = merged;
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b1;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    mem_wr_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            data_q      <= 16'h0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            data_q      <= data_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: byte-addressed memory model with wait-state injection,
// directed vectors plus randomized stores, reset abort and stray-ack cases.
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] mem_b [0:1023];

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_b[{a[9:2], 2'b00} + i] = w[8*i +: 8];
    endtask

    // Caller is positioned just after a falling edge; returns on the falling edge after
    // the operation has fully finished (device back in its ready state).
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             input int rw, input int ww, input bit hold);
        logic        legal;
        logic [31:0] old_w, new_w, base;
        legal = !(sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
        base  = {a[31:2], 2'b00};
        old_w = word_at(a);
        if (legal)
            for (int i = 0; i < (1 << sz); i++) mem_b[a[9:0] + i] = d[8*i +: 8];
        new_w = word_at(a);

        chk("ready_before", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        if (!legal) begin
            chk("err_pulse", {31'b0, err}, 32'd1);
            chk("err_no_done", {31'b0, done}, 32'd0);
            chk("err_no_rd", {31'b0, mem_rd}, 32'd0);
            chk("err_no_wr", {31'b0, mem_wr}, 32'd0);
            chk("err_ready", {31'b0, req_ready}, 32'd1);
            return;
        end
        chk("busy_ready", {31'b0, req_ready}, 32'd0);
        chk("busy_err", {31'b0, err}, 32'd0);
        if (sz != 2'b10) begin
            for (int k = 0; k <= rw; k++) begin
                chk("rd_held", {31'b0, mem_rd}, 32'd1);
                chk("rd_no_wr", {31'b0, mem_wr}, 32'd0);
                chk("rd_addr", mem_addr, base);
                chk("rd_ready", {31'b0, req_ready}, 32'd0);
                if (k == rw) begin
                    mem_ack = 1'b1; mem_rdata = old_w;
                end else begin
                    mem_rdata = $urandom;
                end
                @(negedge clk);
            end
            mem_ack = 1'b0; mem_rdata = $urandom;
        end
        for (int k = 0; k <= ww; k++) begin
            chk("wr_held", {31'b0, mem_wr}, 32'd1);
            chk("wr_no_rd", {31'b0, mem_rd}, 32'd0);
            chk("wr_addr", mem_addr, base);
            chk("wr_data", mem_wdata, new_w);
            chk("wr_no_done", {31'b0, done}, 32'd0);
            chk("wr_ready", {31'b0, req_ready}, 32'd0);
            if (k == ww) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("resp_done", {31'b0, done}, 32'd1);
        chk("resp_no_err", {31'b0, err}, 32'd0);
        chk("resp_wr_low", {31'b0, mem_wr}, 32'd0);
        chk("resp_rd_low", {31'b0, mem_rd}, 32'd0);
        chk("resp_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("idle_done_low", {31'b0, done}, 32'd0);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = 2'b00;
        mem_rdata = '0; mem_ack = 1'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_word(32'h100, 32'h11223344);
        run_store(32'h103, 32'h0000_00AB, 2'b00, 0, 0, 1'b0);
        chk("vec_byte_mem", word_at(32'h100), 32'hAB22_3344);
        set_word(32'h200, 32'h11223344);
        run_store(32'h202, 32'hFFFF_BEEF, 2'b01, 1, 0, 1'b0);
        chk("vec_half_hi_mem", word_at(32'h200), 32'hBEEF_3344);
        set_word(32'h200, 32'h11223344);
        run_store(32'h200, 32'hFFFF_BEEF, 2'b01, 0, 2, 1'b0);
        chk("vec_half_lo_mem", word_at(32'h200), 32'h1122_BEEF);
        run_store(32'h040, 32'hDEAD_BEEF, 2'b10, 0, 3, 1'b0);
        chk("vec_word_mem", word_at(32'h040), 32'hDEAD_BEEF);

        run_store(32'h201, 32'h1234_5678, 2'b01, 0, 0, 1'b0);
        @(negedge clk);
        run_store(32'h202, 32'h1234_5678, 2'b10, 0, 0, 1'b0);
        @(negedge clk);
        run_store(32'h200, 32'h1234_5678, 2'b11, 0, 0, 1'b0);
        @(negedge clk);

        // Stray acks while idle must not start anything.
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_rd", {31'b0, mem_rd}, 32'd0);
            chk("stray_wr", {31'b0, mem_wr}, 32'd0);
            chk("stray_done", {31'b0, done}, 32'd0);
            chk("stray_ready", {31'b0, req_ready}, 32'd1);
        end
        mem_ack = 1'b0;
        @(negedge clk);

        // Back-to-back with req_valid held high.
        run_store(32'h010, 32'hCAFE_F00D, 2'b10, 0, 0, 1'b1);
        run_store(32'h015, 32'h0000_0077, 2'b00, 0, 1, 1'b1);
        run_store(32'h01A, 32'h0000_9988, 2'b01, 2, 0, 1'b1);
        run_store(32'h013, 32'h0, 2'b10, 0, 0, 1'b1);
        run_store(32'h020, 32'h0BAD_CAFE, 2'b10, 1, 1, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of a read wait.
        set_word(32'h300, 32'h5566_7788);
        req_valid = 1'b1; req_addr = 32'h301; req_data = 32'h0000_00EE; req_size = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_rd_on", {31'b0, mem_rd}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd_drop", {31'b0, mem_rd}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done}, 32'd0);
            chk("abort_no_err", {31'b0, err}, 32'd0);
            chk("abort_no_wr", {31'b0, mem_wr}, 32'd0);
        end
        run_store(32'h040, 32'h0123_4567, 2'b10, 0, 0, 1'b0);
        chk("abort_mem_kept", word_at(32'h300), 32'h5566_7788);

        // Randomized mix of sizes, alignments, wait states and valid-hold behaviour.
        for (int n = 0; n < 60; n++) begin
            run_store(32'($urandom_range(0, 1023)), $urandom, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                req_valid = 1'b0;
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("final_idle", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
